// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI3-style responder backed by a word-addressed on-chip SRAM.
// Independent read and write engines, one outstanding burst per direction.
// Optional feature macro: AXI_SLV_RANGE_ERR_EN. When defined, bursts whose start
// address lies at or above MEM_WORDS*4 answer SLVERR and never touch the memory.
// When undefined, address bits above the word index are ignored (aliasing).
module axi_sram_slave #(
  parameter int MEM_WORDS = 1024,
  parameter int MEM_AW    = 10
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic        awvalid,
  output logic        awready,
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  typedef enum logic       {R_IDLE, R_DATA} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

  logic [31:0]       mem_q [MEM_WORDS];
  logic              alive_q;

  r_state_e          r_state_q, r_state_d;
  logic [3:0]        r_id_q;
  logic [MEM_AW-1:0] r_idx_q, r_idx_nxt, ar_idx;
  logic [7:0]        r_len_q, r_cnt_q;
  logic [1:0]        r_burst_q;
  logic              r_oor_q, ar_oor;
  logic [31:0]       r_data_q;
  logic [1:0]        r_resp_q;
  logic              r_last_q;

  w_state_e          w_state_q, w_state_d;
  logic [3:0]        w_id_q;
  logic [MEM_AW-1:0] w_idx_q, w_idx_nxt, aw_idx;
  logic [7:0]        w_len_q, w_cnt_q;
  logic [1:0]        w_burst_q;
  logic              w_oor_q, aw_oor;

  logic              ar_hs, r_hs, aw_hs, w_hs, w_we;
  logic              unused_inputs;

  // Word index of the next beat: FIXED holds, WRAP with a power-of-two beat
  // count cycles the low bits inside its aligned block, everything else increments.
  function automatic logic [MEM_AW-1:0] step_idx(input logic [MEM_AW-1:0] idx,
                                                 input logic [7:0]        len,
                                                 input logic [1:0]        burst);
    logic [MEM_AW-1:0] inc;
    logic [MEM_AW-1:0] mask;
    inc      = idx + 1'b1;
    mask     = MEM_AW'(len[3:0]);
    step_idx = inc;
    if (burst == 2'b00) begin
      step_idx = idx;
    end else if (burst == 2'b10 &&
                 (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) begin
      step_idx = (idx & ~mask) | (inc & mask);
    end
  endfunction

  assign ar_idx = araddr[MEM_AW+1:2];
  assign aw_idx = awaddr[MEM_AW+1:2];

`ifdef AXI_SLV_RANGE_ERR_EN
  assign ar_oor = |araddr[31:MEM_AW+2];
  assign aw_oor = |awaddr[31:MEM_AW+2];
`else
  assign ar_oor = 1'b0;
  assign aw_oor = 1'b0;
`endif

  assign unused_inputs = ^{wid, wlast, arsize, awsize, araddr[1:0], awaddr[1:0],
                           araddr[31:MEM_AW+2], awaddr[31:MEM_AW+2]};

  assign arready   = alive_q && (r_state_q == R_IDLE);
  assign rvalid    = (r_state_q == R_DATA);
  assign rid       = r_id_q;
  assign rdata     = r_data_q;
  assign rresp     = r_resp_q;
  assign rlast     = r_last_q;
  assign awready   = alive_q && (w_state_q == W_IDLE);
  assign wready    = (w_state_q == W_DATA);
  assign bvalid    = (w_state_q == W_RESP);
  assign bid       = w_id_q;
  assign bresp     = w_oor_q ? 2'b10 : 2'b00;

  assign ar_hs     = arvalid && arready;
  assign r_hs      = rvalid && rready;
  assign aw_hs     = awvalid && awready;
  assign w_hs      = wvalid && wready;
  assign w_we      = w_hs && !w_oor_q;
  assign r_idx_nxt = step_idx(r_idx_q, r_len_q, r_burst_q);
  assign w_idx_nxt = step_idx(w_idx_q, w_len_q, w_burst_q);

  // Keeps both address channels closed while reset is held and opens them one edge later.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) alive_q <= 1'b0;
    else       alive_q <= 1'b1;
  end

  // Read engine state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state_q <= R_IDLE;
    else       r_state_q <= r_state_d;
  end

  // Read engine next state: leave R_DATA on the handshake of the final beat.
  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE:  if (ar_hs) r_state_d = R_DATA;
      R_DATA:  if (r_hs && r_cnt_q == r_len_q) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  // Read datapath: the first beat is fetched at address acceptance, later beats at
  // each accepted beat so rvalid never drops mid-burst.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_id_q    <= '0;
      r_idx_q   <= '0;
      r_len_q   <= '0;
      r_cnt_q   <= '0;
      r_burst_q <= '0;
      r_oor_q   <= 1'b0;
      r_data_q  <= '0;
      r_resp_q  <= 2'b00;
      r_last_q  <= 1'b0;
    end else if (ar_hs) begin
      r_id_q    <= arid;
      r_idx_q   <= ar_idx;
      r_len_q   <= arlen;
      r_cnt_q   <= '0;
      r_burst_q <= arburst;
      r_oor_q   <= ar_oor;
      r_data_q  <= ar_oor ? 32'h0 : mem_q[ar_idx];
      r_resp_q  <= ar_oor ? 2'b10 : 2'b00;
      r_last_q  <= (arlen == 8'd0);
    end else if (r_hs && r_cnt_q != r_len_q) begin
      r_cnt_q   <= r_cnt_q + 8'd1;
      r_idx_q   <= r_idx_nxt;
      r_data_q  <= r_oor_q ? 32'h0 : mem_q[r_idx_nxt];
      r_last_q  <= (r_cnt_q + 8'd1 == r_len_q);
    end else if (r_hs) begin
      r_last_q  <= 1'b0;
    end
  end

  // Write engine state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) w_state_q <= W_IDLE;
    else       w_state_q <= w_state_d;
  end

  // Write engine next state: the beat count, not wlast, ends the data phase.
  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE:  if (aw_hs) w_state_d = W_DATA;
      W_DATA:  if (w_hs && w_cnt_q == w_len_q) w_state_d = W_RESP;
      W_RESP:  if (bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  // Write burst bookkeeping: address/ID capture and per-beat index stepping.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_id_q    <= '0;
      w_idx_q   <= '0;
      w_len_q   <= '0;
      w_cnt_q   <= '0;
      w_burst_q <= '0;
      w_oor_q   <= 1'b0;
    end else if (aw_hs) begin
      w_id_q    <= awid;
      w_idx_q   <= aw_idx;
      w_len_q   <= awlen;
      w_cnt_q   <= '0;
      w_burst_q <= awburst;
      w_oor_q   <= aw_oor;
    end else if (w_hs) begin
      w_cnt_q   <= w_cnt_q + 8'd1;
      w_idx_q   <= w_idx_nxt;
    end
  end

  // Byte-enabled memory write; reads sample the array before this edge's update.
  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem_q[w_idx_q][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed testbench for axi_sram_slave: table of single-beat write/readback
// vectors plus hand-written burst, backpressure and reset sequences.
module tb_axi_sram_slave;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic [3:0]  arid = '0, awid = '0, wid = '0, rid, bid;
  logic [31:0] araddr = '0, awaddr = '0, wdata = '0, rdata;
  logic [7:0]  arlen = '0, awlen = '0;
  logic [2:0]  arsize = 3'b010, awsize = 3'b010;
  logic [1:0]  arburst = '0, awburst = '0, rresp, bresp;
  logic        arvalid = 1'b0, awvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0;
  logic        rready = 1'b0, bready = 1'b0;
  logic [3:0]  wstrb = '0;
  logic        arready, awready, wready, rvalid, rlast, bvalid;

  int          nCompared = 0;
  int          nMismatched = 0;
  logic [31:0] wBuf [16];
  logic [31:0] rExp [16];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdat;
    logic [3:0]  strb;
    logic [31:0] expRead;
  } vec_t;

  vec_t vecs [8];

  axi_sram_slave dut (
    .clk(clk), .rstn(rstn),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic timeoutFail(input string name);
    nCompared++;
    nMismatched++;
    $display("[TB] FAIL %s: no handshake within 100 cycles, expected one", name);
  endtask

  // Write burst of len+1 beats taken from wBuf, then collect and check the response.
  task automatic applyStimulus(input logic [31:0] addr, input logic [7:0] len,
                               input logic [1:0] burst, input logic [3:0] id,
                               input logic [3:0] strb, input logic [1:0] expResp);
    int n;
    @(negedge clk);
    awaddr = addr; awlen = len; awburst = burst; awid = id; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) timeoutFail("aw_handshake");
    @(negedge clk);
    awvalid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      wdata = wBuf[b]; wstrb = strb; wid = id; wlast = (b == int'(len)); wvalid = 1'b1;
      n = 0;
      while (!wready && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) timeoutFail("w_handshake");
      if (b == int'(len)) checkOutput("bvalid_before_last_w", {31'b0, bvalid}, 32'd0);
      @(negedge clk);
    end
    wvalid = 1'b0; wlast = 1'b0;
    checkOutput("bvalid_after_last_w", {31'b0, bvalid}, 32'd1);
    bready = 1'b1;
    n = 0;
    while (!bvalid && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) timeoutFail("b_handshake");
    checkOutput("bid", {28'b0, bid}, {28'b0, id});
    checkOutput("bresp", {30'b0, bresp}, {30'b0, expResp});
    @(negedge clk);
    bready = 1'b0;
    checkOutput("awready_after_b", {31'b0, awready}, 32'd1);
  endtask

  // Read burst; mode 0 keeps rready high, mode 1 toggles it 1,0,1,0...
  task automatic readBurst(input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [3:0] id,
                           input int mode, input logic [1:0] expResp);
    int n, k, cyc;
    bit held;
    logic [31:0] heldData;
    @(negedge clk);
    araddr = addr; arlen = len; arburst = burst; arid = id; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) timeoutFail("ar_handshake");
    @(negedge clk);
    arvalid = 1'b0;
    k = 0; cyc = 0; held = 0; heldData = '0;
    while (k <= int'(len) && cyc < 100) begin
      rready = (mode == 0) ? 1'b1 : (cyc % 2 == 0);
      if (rvalid) begin
        if (held) checkOutput("rdata_stable", rdata, heldData);
        if (rready) begin
          checkOutput($sformatf("rdata_beat%0d", k), rdata, rExp[k]);
          checkOutput($sformatf("rlast_beat%0d", k), {31'b0, rlast},
                      {31'b0, (k == int'(len))});
          checkOutput("rid", {28'b0, rid}, {28'b0, id});
          checkOutput("rresp", {30'b0, rresp}, {30'b0, expResp});
          checkOutput("arready_busy", {31'b0, arready}, 32'd0);
          k++;
          held = 0;
        end else begin
          held = 1;
          heldData = rdata;
        end
      end
      cyc++;
      @(negedge clk);
    end
    rready = 1'b0;
    if (k <= int'(len)) timeoutFail("r_beats");
    checkOutput("rvalid_after_last", {31'b0, rvalid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{32'h040, 32'h1234_5678, 4'b1111, 32'h1234_5678};
    vecs[1] = '{32'h040, 32'hFFFF_FFFF, 4'b0100, 32'h12FF_5678};
    vecs[2] = '{32'h040, 32'h0000_0000, 4'b1001, 32'h00FF_5600};
    vecs[3] = '{32'h048, 32'hA5A5_A5A5, 4'b1111, 32'hA5A5_A5A5};
    vecs[4] = '{32'h048, 32'h5A5A_5A5A, 4'b0010, 32'hA5A5_5AA5};
    vecs[5] = '{32'h048, 32'h1111_1111, 4'b0000, 32'hA5A5_5AA5};
    vecs[6] = '{32'h014, 32'h1122_3344, 4'b1111, 32'h1122_3344};
    vecs[7] = '{32'h014, 32'hDEAD_BEEF, 4'b0011, 32'h1122_BEEF};

    #2 rstn = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_arready", {31'b0, arready}, 32'd0);
    checkOutput("reset_awready", {31'b0, awready}, 32'd0);
    checkOutput("reset_wready",  {31'b0, wready},  32'd0);
    checkOutput("reset_rvalid",  {31'b0, rvalid},  32'd0);
    checkOutput("reset_bvalid",  {31'b0, bvalid},  32'd0);
    checkOutput("reset_rdata",   rdata, 32'd0);
    checkOutput("reset_rlast",   {31'b0, rlast},   32'd0);
    rstn = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_arready", {31'b0, arready}, 32'd1);

    $display("[TB] table-driven single-beat vectors");
    for (int i = 0; i < 8; i++) begin
      wBuf[0] = vecs[i].wdat;
      applyStimulus(vecs[i].addr, 8'd0, 2'b01, 4'(i), vecs[i].strb, 2'b00);
      rExp[0] = vecs[i].expRead;
      readBurst(vecs[i].addr, 8'd0, 2'b01, 4'(i + 8), 0, 2'b00);
    end

    $display("[TB] wrap write and reads");
    wBuf[0] = 32'hAAAA_0001; wBuf[1] = 32'hBBBB_0002;
    wBuf[2] = 32'hCCCC_0003; wBuf[3] = 32'hDDDD_0004;
    applyStimulus(32'h008, 8'd3, 2'b10, 4'd2, 4'b1111, 2'b00);
    rExp[0] = 32'hAAAA_0001; rExp[1] = 32'hBBBB_0002;
    rExp[2] = 32'hCCCC_0003; rExp[3] = 32'hDDDD_0004;
    readBurst(32'h008, 8'd3, 2'b10, 4'd1, 0, 2'b00);
    rExp[0] = 32'hCCCC_0003; rExp[1] = 32'hDDDD_0004;
    rExp[2] = 32'hAAAA_0001; rExp[3] = 32'hBBBB_0002;
    readBurst(32'h000, 8'd3, 2'b01, 4'd1, 0, 2'b00);
    rExp[0] = 32'hAAAA_0001; rExp[1] = 32'hBBBB_0002;
    rExp[2] = 32'hCCCC_0003; rExp[3] = 32'hDDDD_0004;
    readBurst(32'h008, 8'd3, 2'b10, 4'd1, 1, 2'b00);

    $display("[TB] fixed burst and wrap with unsupported length");
    wBuf[0] = 32'h0F0F_0001; wBuf[1] = 32'h0F0F_0002; wBuf[2] = 32'h0F0F_0003;
    applyStimulus(32'h060, 8'd2, 2'b00, 4'd4, 4'b1111, 2'b00);
    rExp[0] = 32'h0F0F_0003; rExp[1] = 32'h0F0F_0003;
    readBurst(32'h060, 8'd1, 2'b00, 4'd5, 0, 2'b00);
    wBuf[0] = 32'h5000_0031; wBuf[1] = 32'h5000_0032; wBuf[2] = 32'h5000_0033;
    applyStimulus(32'h07C, 8'd2, 2'b10, 4'd6, 4'b1111, 2'b00);
    rExp[0] = 32'h5000_0031; rExp[1] = 32'h5000_0032; rExp[2] = 32'h5000_0033;
    readBurst(32'h07C, 8'd2, 2'b01, 4'd7, 0, 2'b00);

    $display("[TB] reset in the middle of a read burst");
    for (int i = 0; i < 8; i++) wBuf[i] = 32'h7700_0000 + 32'(i);
    applyStimulus(32'h100, 8'd7, 2'b01, 4'd3, 4'b1111, 2'b00);
    @(negedge clk);
    araddr = 32'h100; arlen = 8'd7; arburst = 2'b01; arid = 4'd9; arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    rready = 1'b1;
    checkOutput("abort_beat1", rdata, 32'h7700_0000);
    @(negedge clk);
    checkOutput("abort_beat2", rdata, 32'h7700_0001);
    rstn = 1'b0; rready = 1'b0;
    #1;
    checkOutput("abort_rvalid",  {31'b0, rvalid},  32'd0);
    checkOutput("abort_arready", {31'b0, arready}, 32'd0);
    checkOutput("abort_rdata",   rdata, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    checkOutput("release_arready", {31'b0, arready}, 32'd1);
    for (int i = 0; i < 8; i++) rExp[i] = 32'h7700_0000 + 32'(i);
    readBurst(32'h100, 8'd7, 2'b01, 4'd9, 0, 2'b00);

    $display("[TB] top-of-memory wrap and out-of-range addresses");
    wBuf[0] = 32'h0000_0FFC; wBuf[1] = 32'h0000_1234;
    applyStimulus(32'hFFC, 8'd1, 2'b01, 4'd1, 4'b1111, 2'b00);
    rExp[0] = 32'h0000_0FFC; rExp[1] = 32'h0000_1234;
    readBurst(32'hFFC, 8'd1, 2'b01, 4'd2, 0, 2'b00);
`ifdef AXI_SLV_RANGE_ERR_EN
    rExp[0] = 32'h0;
    readBurst(32'h1000, 8'd0, 2'b01, 4'd3, 0, 2'b10);
    wBuf[0] = 32'h0BAD_0BAD;
    applyStimulus(32'h1000, 8'd0, 2'b01, 4'd4, 4'b1111, 2'b10);
    rExp[0] = 32'h0000_1234;
`else
    rExp[0] = 32'h0000_1234;
    readBurst(32'h1000, 8'd0, 2'b01, 4'd3, 0, 2'b00);
    wBuf[0] = 32'h0BAD_0BAD;
    applyStimulus(32'h1000, 8'd0, 2'b01, 4'd4, 4'b1111, 2'b00);
    rExp[0] = 32'h0BAD_0BAD;
`endif
    readBurst(32'h000, 8'd0, 2'b01, 4'd5, 0, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
